// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes two coin sensors, debounces them,
// reports one accepted coin code per insertion and refuses ambiguous or inhibited coins.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LOCKOUT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    input  logic       inhibit,
    output logic [1:0] in_price,
    output logic       reject,
    output logic [7:0] coin_cnt
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CODE_W  = 2;
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CODE_W-1:0] CODE_NONE = 2'b00;
    localparam logic [CODE_W-1:0] CODE_FIVE = 2'b01;
    localparam logic [CODE_W-1:0] CODE_TEN  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    logic [1:0]        r_sync5;
    logic [1:0]        r_sync10;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_ten;
    logic [CODE_W-1:0] r_in_price;
    logic              r_reject;
    logic [CNT_W-1:0]  r_coin_cnt;

    logic              w_s5;
    logic              w_s10;
    logic              w_cap;
    logic              w_oth;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_is_ten_nxt;
    logic              w_accept;
    logic              w_refuse;
    logic [CODE_W-1:0] w_in_price_nxt;
    logic              w_reject_nxt;
    logic [CNT_W-1:0]  w_coin_cnt_nxt;

    assign w_s5  = r_sync5[1];
    assign w_s10 = r_sync10[1];
    // Captured line and the opposite line while a coin is being qualified.
    assign w_cap = r_is_ten ? w_s10 : w_s5;
    assign w_oth = r_is_ten ? w_s5  : w_s10;

    // Two-flop synchronizers for the asynchronous sensor lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync5  <= 2'b00;
            r_sync10 <= 2'b00;
        end else begin
            r_sync5  <= {r_sync5[0],  coin5_raw};
            r_sync10 <= {r_sync10[0], coin10_raw};
        end
    end

    // State register with the shared qualification/lockout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_ten <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_ten <= w_is_ten_nxt;
        end
    end

    // Next-state logic; also flags the acceptance and refusal events.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_is_ten_nxt = r_is_ten;
        w_accept     = 1'b0;
        w_refuse     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((w_s5 ^ w_s10) && !inhibit) begin
                    w_state_nxt  = ST_QUAL;
                    w_cnt_nxt    = CNT_W'(1);
                    w_is_ten_nxt = w_s10;
                end else if (w_s5 || w_s10) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_refuse    = 1'b1;
                end
            end
            ST_QUAL: begin
                if (w_oth) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_refuse    = 1'b1;
                end else if (w_cap) begin
                    if (r_cnt == DEB_LAST) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = '0;
                        w_accept    = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    // Line dropped early: treat as a glitch, silently.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HOLD: begin
                if (!w_s5 && !w_s10) begin
                    w_state_nxt = ST_LOCKOUT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOCKOUT: begin
                if (r_cnt == LOCK_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_in_price_nxt = CODE_NONE;
        w_reject_nxt   = 1'b0;
        w_coin_cnt_nxt = r_coin_cnt;
        if (w_accept) begin
            w_in_price_nxt = r_is_ten ? CODE_TEN : CODE_FIVE;
            w_coin_cnt_nxt = r_coin_cnt + CNT_W'(1);
        end
        if (w_refuse) begin
            w_reject_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_price <= CODE_NONE;
            r_reject   <= 1'b0;
            r_coin_cnt <= '0;
        end else begin
            r_in_price <= w_in_price_nxt;
            r_reject   <= w_reject_nxt;
            r_coin_cnt <= w_coin_cnt_nxt;
        end
    end

    assign in_price = r_in_price;
    assign reject   = r_reject;
    assign coin_cnt = r_coin_cnt;

endmodule
